// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU operation sequencer: opcodes, FSM states and sizing helpers.
package alu_op_sequencer_pkg;

    localparam int unsigned DefaultWidth = 3;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpMul = 2'b10,
        OpNeg = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StNeg  = 3'd1,
        StAdd  = 3'd2,
        StMul  = 3'd3,
        StDone = 3'd4
    } state_e;

    // Bit counter needs at least one bit even when WIDTH is 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_adder_unit.sv
// Shared adder: computes x + y or x + ~y + carry_in; carry out is discarded.
module seq_adder_unit #(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             invert_y,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] y_sel;

    always_comb begin
        y_sel = invert_y ? ~y : y;
        sum   = x + y_sel + WIDTH'(carry_in);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ADD/SUB/NEG/MUL controller sequencing a single shared 2*WIDTH-bit adder,
// with valid/ready handshakes on the request and result sides.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [RW-1:0]   a_q, a_d;
    logic [RW-1:0]   b_q, b_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [RW-1:0]   add_x;
    logic [RW-1:0]   add_y;
    logic            add_inv;
    logic            add_cin;
    logic [RW-1:0]   add_sum;

    seq_adder_unit #(
        .WIDTH (RW)
    ) u_adder (
        .x        (add_x),
        .y        (add_y),
        .invert_y (add_inv),
        .carry_in (add_cin),
        .sum      (add_sum)
    );

    // Operand muxes for the shared adder; MUL is the default path (acc + (a << i)).
    always_comb begin
        add_x   = acc_q;
        add_y   = a_q << cnt_q;
        add_inv = 1'b0;
        add_cin = 1'b0;
        unique case (state_q)
            StNeg: begin
                add_x   = '0;
                add_y   = b_q;
                add_inv = 1'b1;
                add_cin = 1'b1;
            end
            StAdd: begin
                add_x = a_q;
                add_y = b_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = op_e'(op);
                    a_d   = RW'(a);
                    b_d   = RW'(b);
                    acc_d = '0;
                    cnt_d = '0;
                    unique case (op_e'(op))
                        OpAdd:   state_d = StAdd;
                        OpMul:   state_d = StMul;
                        default: state_d = StNeg;
                    endcase
                end
            end
            StNeg: begin
                acc_d = add_sum;
                if (op_q == OpSub) begin
                    // SUB reuses the ADD step with the negated subtrahend.
                    b_d     = add_sum;
                    state_d = StAdd;
                end else begin
                    state_d = StDone;
                end
            end
            StAdd: begin
                acc_d   = add_sum;
                state_d = StDone;
            end
            StMul: begin
                if (b_q[cnt_q]) begin
                    acc_d = add_sum;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpAdd;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone);
        result    = acc_q;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed checks of alu_op_sequencer against an arithmetic reference model.
module tb_alu_op_sequencer;

    localparam int unsigned W  = 3;
    localparam int unsigned RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    function automatic int ref_result(input logic [1:0] o, input int x, input int y);
        int r;
        case (o)
            2'b00:   r = x + y;
            2'b01:   r = x - y;
            2'b10:   r = x * y;
            default: r = -y;
        endcase
        return r & ((1 << RW) - 1);
    endfunction

    function automatic int ref_latency(input logic [1:0] o);
        case (o)
            2'b01:   return 3;
            2'b10:   return W + 1;
            default: return 2;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Issues one request from IDLE with out_ready high and checks latency, value and pulse width.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int cyc;
        int exp_res;
        exp_res   = ref_result(o, int'(x), int'(y));
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b1;
        check("in_ready_before_accept", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("latency op%0d a%0d b%0d", o, x, y), cyc, ref_latency(o));
        check($sformatf("result op%0d a%0d b%0d", o, x, y), int'(result), exp_res);
        check("in_ready_in_done", int'(in_ready), 0);
        @(posedge clk); #1;
        check("out_valid_single_cycle", int'(out_valid), 0);
    endtask

    int stall_res;
    int cyc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Directed corner cases.
        do_op(2'b00, 3'd5, 3'd3);
        do_op(2'b01, 3'd2, 3'd5);
        do_op(2'b01, 3'd5, 3'd2);
        do_op(2'b10, 3'd7, 3'd7);
        do_op(2'b10, 3'd0, 3'd7);
        do_op(2'b11, 3'd0, 3'd3);
        do_op(2'b11, 3'd0, 3'd0);

        // Randomised operations.
        for (int i = 0; i < 24; i++) begin
            do_op(2'($urandom), W'($urandom), W'($urandom));
        end

        // Stall in DONE with a queued request held on the input.
        in_valid  = 1'b1;
        op        = 2'b10;
        a         = 3'd6;
        b         = 3'd5;
        out_ready = 1'b0;
        @(posedge clk); #1;
        op = 2'b00; a = 3'd7; b = 3'd6;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("stall_latency", cyc, ref_latency(2'b10));
        stall_res = ref_result(2'b10, 6, 5);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_result", int'(result), stall_res);
            check("stall_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_stall_idle", int'(in_ready), 1);
        check("post_stall_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        check("queued_accepted", int'(busy), 1);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("queued_latency", cyc, ref_latency(2'b00));
        check("queued_result", int'(result), ref_result(2'b00, 7, 6));
        @(posedge clk); #1;

        // Reset in the middle of a multiply.
        in_valid = 1'b1;
        op       = 2'b10;
        a        = 3'd7;
        b        = 3'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_mul_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 0);
        for (int i = 0; i < int'(W) + 2; i++) begin
            @(posedge clk); #1;
            check("abort_no_stale", int'(out_valid), 0);
        end
        do_op(2'b01, 3'd1, 3'd6);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
